// File: rtl/ifq_pkg.sv
// Shared constants and the queue entry type for the instruction fetch queue.
// The top level's IFQ_BYPASS_EN option does not affect this package.
package ifq_pkg;

    localparam int IFQ_DATA_WIDTH = 32;
    localparam logic [IFQ_DATA_WIDTH-1:0] IFQ_RESET_PC = 32'h0000_0000;
    localparam int PC_INCR = 4;

    typedef struct packed {
        logic [IFQ_DATA_WIDTH-1:0] instr;
        logic [IFQ_DATA_WIDTH-1:0] pc;
    } ifq_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Circular buffer of {instr, pc} entries with wrap-around pointers and occupancy.
// The head entry reads as zero while the buffer is empty.
module ifq_storage
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_flush,
    input  logic                  i_wr_en,
    input  ifq_entry_t            i_wr_data,
    input  logic                  i_rd_en,
    output ifq_entry_t            o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    ifq_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({i_wr_en, i_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: owns the PC, issues fixed-latency icache requests, queues replies.
// Define IFQ_BYPASS_EN to forward a reply straight to dispatch when the queue is empty.
module instruction_fetch_queue
    import ifq_pkg::*;
#(
    parameter int                    DATA_WIDTH = IFQ_DATA_WIDTH,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFQ_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  icache_rd_en,
    output logic [DATA_WIDTH-1:0] icache_addr,
    input  logic [DATA_WIDTH-1:0] icache_data,
    input  logic                  icache_valid,
    input  logic                  Read_enable,
    input  logic                  jump_branch_valid,
    input  logic [DATA_WIDTH-1:0] jump_branch_address,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] PC_out,
    output logic                  empty,
    output logic                  full
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_req_pc;
    logic                  r_inflight;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_occupancy;
    logic          w_req;
    logic          w_resp;
    logic          w_bypass;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_st_empty;
    ifq_entry_t    w_wr_data;
    ifq_entry_t    w_head;

    // Reserve a slot for the in-flight reply so a write never meets a full queue
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_req = !reset && !jump_branch_valid
                && (w_occupancy < (CW + 1)'(DEPTH));

    assign icache_rd_en = w_req;
    assign icache_addr  = r_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_inflight <= 1'b0;
        end else if (jump_branch_valid) begin
            r_pc       <= jump_branch_address & ~DATA_WIDTH'(3);
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + DATA_WIDTH'(PC_INCR);
            end
        end
    end

    assign w_resp = icache_valid && r_inflight
                 && !jump_branch_valid && !reset;

`ifdef IFQ_BYPASS_EN
    assign w_bypass = w_resp && w_st_empty;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed reply popped in the same cycle never occupies a slot
    assign w_wr_en = w_resp && !(w_bypass && Read_enable);
    assign w_rd_en = Read_enable && !w_st_empty && !jump_branch_valid;

    assign w_wr_data = '{instr: icache_data, pc: r_req_pc};

    ifq_storage #(
        .DEPTH(DEPTH)
    ) u_storage (
        .clk      (clk),
        .reset    (reset),
        .i_flush  (jump_branch_valid),
        .i_wr_en  (w_wr_en),
        .i_wr_data(w_wr_data),
        .i_rd_en  (w_rd_en),
        .o_head   (w_head),
        .o_count  (w_count),
        .o_full   (full),
        .o_empty  (w_st_empty)
    );

    assign empty       = w_st_empty && !w_bypass;
    assign Instruction = w_bypass ? icache_data : w_head.instr;
    assign PC_out      = w_bypass ? r_req_pc : w_head.pc;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue model.
// Builds with or without IFQ_BYPASS_EN; expectations follow the same define.
module tb_instruction_fetch_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          icache_rd_en;
    logic [DW-1:0] icache_addr;
    logic [DW-1:0] icache_data;
    logic          icache_valid;
    logic          Read_enable;
    logic          jump_branch_valid;
    logic [DW-1:0] jump_branch_address;
    logic [DW-1:0] Instruction;
    logic [DW-1:0] PC_out;
    logic          empty;
    logic          full;

    always #5 clk = ~clk;

    instruction_fetch_queue #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .icache_rd_en       (icache_rd_en),
        .icache_addr        (icache_addr),
        .icache_data        (icache_data),
        .icache_valid       (icache_valid),
        .Read_enable        (Read_enable),
        .jump_branch_valid  (jump_branch_valid),
        .jump_branch_address(jump_branch_address),
        .Instruction        (Instruction),
        .PC_out             (PC_out),
        .empty              (empty),
        .full               (full)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a plain FIFO of (instr, pc) plus the fetch PC
    logic [31:0] mq_i[$];
    logic [31:0] mq_p[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_inflight;
    bit          m_resp;
    bit          m_byp;
    bit          m_rd;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fdat(input logic [31:0] pc);
        return 32'hA0 + (pc >> 2);
    endfunction

    task automatic drive(input bit spur, input logic [31:0] data);
        bit          e_empty;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        icache_valid = m_inflight || spur;
        icache_data  = data;
        m_data       = data;
        #1;
        m_resp = icache_valid && m_inflight && !jump_branch_valid && !reset;
        m_byp  = BYP && m_resp && (mq_i.size() == 0);
        m_rd   = !reset && !jump_branch_valid
              && ((mq_i.size() + (m_inflight ? 1 : 0)) < DEPTH);
        e_empty = (mq_i.size() == 0) && !m_byp;
        e_instr = m_byp ? data : (mq_i.size() > 0 ? mq_i[0] : 32'h0);
        e_pc    = m_byp ? m_req_pc : (mq_p.size() > 0 ? mq_p[0] : 32'h0);
        chk("rd_en", 32'(icache_rd_en), 32'(m_rd));
        chk("addr", icache_addr, m_pc);
        chk("empty", 32'(empty), 32'(e_empty));
        chk("full", 32'(full), 32'(mq_i.size() == DEPTH));
        chk("instr", Instruction, e_instr);
        chk("pc_out", PC_out, e_pc);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            mq_i.delete();
            mq_p.delete();
            m_pc       = 32'h0;
            m_inflight = 1'b0;
        end else if (jump_branch_valid) begin
            mq_i.delete();
            mq_p.delete();
            m_pc       = jump_branch_address & 32'hFFFF_FFFC;
            m_inflight = 1'b0;
        end else begin
            if (!(m_byp && Read_enable)) begin
                if (Read_enable && mq_i.size() > 0) begin
                    void'(mq_i.pop_front());
                    void'(mq_p.pop_front());
                end
                if (m_resp) begin
                    mq_i.push_back(m_data);
                    mq_p.push_back(m_req_pc);
                end
            end
            if (m_rd) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
            end
            m_inflight = m_rd;
        end
        @(negedge clk);
    endtask

    task automatic step(input bit spur, input logic [31:0] data);
        drive(spur, data);
        tick();
    endtask

    initial begin
        logic [31:0] nxt;
        logic [31:0] wexp;
        int          re_pct;
        bit          spur;

        reset               = 1'b1;
        Read_enable         = 1'b0;
        jump_branch_valid   = 1'b0;
        jump_branch_address = '0;
        icache_valid        = 1'b0;
        icache_data         = '0;
        m_pc                = 32'h0;
        m_req_pc            = 32'h0;
        m_inflight          = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0);
        end
        reset = 1'b0;
        #1;
        chk("rst_first_addr", icache_addr, 32'h0);
        chk("rst_first_req", 32'(icache_rd_en), 32'h1);

        // Fill with no pops
        for (int i = 0; i < 8; i++) begin
            step(1'b0, fdat(m_req_pc));
        end
        #1;
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_no_req", 32'(icache_rd_en), 32'h0);
        chk("fill_head_pc", PC_out, 32'h0);
        chk("fill_head_instr", Instruction, 32'hA0);

        // Drain while refilling: head PC must advance by 4 every cycle
        Read_enable = 1'b1;
        nxt = 32'h0;
        for (int i = 0; i < 16; i++) begin
            chk("drain_seq", PC_out, nxt);
            nxt = nxt + 32'd4;
            step(1'b0, fdat(m_req_pc));
        end

        // Redirect with a reply in flight
        jump_branch_valid   = 1'b1;
        jump_branch_address = 32'h0000_0103;
        step(1'b0, 32'hDEAD_BEEF);
        jump_branch_valid = 1'b0;
        Read_enable       = 1'b0;
        drive(1'b0, 32'h0);
        chk("redir_empty", 32'(empty), 32'h1);
        chk("redir_addr", icache_addr, 32'h0000_0100);
        chk("redir_req", 32'(icache_rd_en), 32'h1);
        tick();
        step(1'b0, fdat(m_req_pc));
        chk("redir_head_pc", PC_out, 32'h0000_0100);
        chk("redir_head_instr", Instruction, 32'hE0);

        // Randomized traffic with redirects, resets and stray replies
        for (int i = 0; i < 600; i++) begin
            re_pct              = ((i / 100) % 2 == 0) ? 30 : 80;
            reset               = ($urandom_range(0, 99) == 0);
            jump_branch_valid   = ($urandom_range(0, 15) == 0);
            jump_branch_address = $urandom;
            Read_enable         = ($urandom_range(0, 99) < re_pct);
            spur = !m_inflight && ($urandom_range(0, 7) == 0);
            step(spur, $urandom);
        end
        reset = 1'b0;

        // PC wraps past the top of the address space
        jump_branch_valid   = 1'b1;
        jump_branch_address = 32'hFFFF_FFF6;
        Read_enable         = 1'b1;
        step(1'b0, 32'h0);
        jump_branch_valid = 1'b0;
        wexp = 32'hFFFF_FFF4;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("wrap_addr", icache_addr, wexp);
            wexp = wexp + 32'd4;
            step(1'b0, $urandom);
        end

        // Reply arriving at an empty queue while dispatch is reading
        jump_branch_valid   = 1'b1;
        jump_branch_address = 32'h0000_0040;
        Read_enable         = 1'b1;
        step(1'b0, 32'h0);
        jump_branch_valid = 1'b0;
        step(1'b0, 32'h0);
        drive(1'b0, 32'h0000_0013);
        chk("byp_empty", 32'(empty), BYP ? 32'h0 : 32'h1);
        chk("byp_instr", Instruction, BYP ? 32'h13 : 32'h0);
        chk("byp_pc", PC_out, BYP ? 32'h40 : 32'h0);
        tick();
        Read_enable = 1'b0;
        step(1'b0, 32'h0000_0077);
        chk("byp_after_pc", PC_out, BYP ? 32'h44 : 32'h40);
        chk("byp_after_full", 32'(full), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

- Fetch stage that feeds the dispatch unit.
- Owns the program counter and issues sequential fetch requests to a fixed-latency instruction cache.
- Buffers returned instructions, each paired with its PC, in a circular queue. The dispatch unit reads the queue through the `empty` / `Instruction` / `PC_out` / `Read_enable` handshake.
- Flushes and redirects on the dispatch unit's `jump_branch_valid` / `jump_branch_address`.

## Interface
- DATA_WIDTH, 32, instruction and PC width
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk  in  1  clock; one clock domain; reset is synchronous and active-high
- reset  in  1  synchronous, active-high
- icache_rd_en  out  1  fetch request this cycle
- icache_addr  out  DATA_WIDTH  fetch address (current PC)
- icache_data  in  DATA_WIDTH  fetched instruction
- icache_valid  in  1  response qualifier; returns exactly 1 cycle after the request
- Read_enable  in  1  dispatch pops the head entry
- jump_branch_valid  in  1  redirect/flush request
- jump_branch_address  in  DATA_WIDTH  redirect target
- Instruction  out  DATA_WIDTH  head instruction; 0 when empty
- PC_out  out  DATA_WIDTH  head PC; 0 when empty
- empty  out  1  queue holds no valid entry
- full  out  1  count == DEPTH

## Operation
- State registers:
  - pc
  - wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH)
  - count (log2 DEPTH + 1 bits)
  - inflight (registered icache_rd_en)
- Reset values: pc=RESET_PC, pointers=0, count=0, inflight=0. Outputs: icache_rd_en=0, empty=1, full=0, Instruction=0, PC_out=0.
- Fetch request:
  - icache_rd_en = !reset && !jump_branch_valid && (count + inflight < DEPTH).
  - icache_addr = pc.
  - On a request, pc <= pc + 4, modulo 2^DATA_WIDTH (0xFFFFFFFC wraps to 0).
- Response write:
  - Condition: icache_valid && inflight && !jump_branch_valid.
  - Writes {icache_data, pc_of_request} at wr_ptr.
  - A second pc register (req_pc) holds the PC of the in-flight request.
  - icache_valid without inflight is ignored.
- Pop: Read_enable && !empty && !jump_branch_valid advances rd_ptr. Read_enable while empty is ignored.
- Count: a write and a pop in the same cycle leave count unchanged. The admission rule guarantees a write is never accepted while full.
- Redirect (jump_branch_valid=1 in cycle t):
  - Pointers and count cleared at the end of t.
  - pc <= {jump_branch_address[31:2], 2'b00}.
  - No request is issued in t.
  - A response arriving in t is discarded.
  - Pop is ignored.
- Reset asserted mid-operation: same as redirect, but pc <= RESET_PC. Reset has priority over redirect.

## Timing
- Request in cycle t; response in t+1; entry is visible on the outputs (empty=0) at t+2.
- With IFQ_BYPASS_EN defined, the entry is visible in t+1 (see Configuration).
- Outputs are combinational from the head entry and count. Pop takes effect at the next edge.
- Redirect in t: the first request to the target is issued in t+1; its instruction appears at t+3 (t+2 with bypass).
- Steady state with dispatch reading every cycle: one instruction per cycle after the initial 2-cycle fill.

## Configuration
- IFQ_BYPASS_EN defined, when the queue is empty and a valid response arrives:
  - The response drives Instruction/PC_out combinationally and empty=0 in the same cycle.
  - If Read_enable is also 1, the entry is consumed and never written; count stays 0.
- IFQ_BYPASS_EN undefined: no bypass; the write→read latency is always 1 cycle.

## Structure
- Package ifq_pkg holds:
  - DATA_WIDTH default
  - RESET_PC default
  - PC_INCR=4
  - the entry typedef {instr, pc}
- One sub-module, ifq_storage: circular buffer holding the entry array, pointers, count, full and empty. The top level holds pc, req_pc, inflight, admission, redirect and bypass logic.

## Test plan
- Reset:
  - Stimulus: reset held 3 cycles.
  - Response: empty=1, full=0, icache_rd_en=0, Instruction=0, PC_out=0. The first request after release has icache_addr=0.
- Fill, no pops:
  - Stimulus: Read_enable=0, cache returns 0xA0+n.
  - Response: requests at 0, 4, 8, 12 only; full=1; icache_rd_en stays 0. Head: PC_out=0, Instruction=0xA0.
- Drain while refilling:
  - Stimulus: Read_enable=1 every cycle after fill.
  - Response: PC_out sequence 0, 4, 8, … with no gaps; count steady; no overflow.
- Redirect with a response in flight:
  - Stimulus: jump_branch_valid=1, jump_branch_address=0x103.
  - Response: empty=1 next cycle; the response in the redirect cycle is dropped. Next icache_addr=0x100; the first PC_out=0x100.
- Wrap:
  - Stimulus: RESET_PC=0xFFFFFFF8.
  - Response: icache_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x0; queue pointers wrap past DEPTH correctly.
- Bypass (IFQ_BYPASS_EN):
  - Stimulus: empty queue; response 0x00000013 at PC 0x40; Read_enable=1 in the same cycle.
  - Response: Instruction=0x13, PC_out=0x40 that cycle; count remains 0.
